// File: rtl/datamem_byte.sv
// ----------------------------------------------------------------------------
// datamem_byte
//   Byte-addressable 32-bit data memory with byte/half/word loads and stores.
//   Memory is zero-filled by a hardware clear sweep after every reset; loads
//   and stores complete one cycle after acceptance with a registered result.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous active-low reset
//   req_DM      in   1       access request (one per cycle)
//   we_DM       in   1       1 = store, 0 = load
//   size_DM     in   2       00 byte, 01 half, 10 word, 11 illegal
//   unsigned_DM in   1       load extension: 1 zero, 0 sign
//   addDM       in   ADDR_W  byte address (wraps modulo 4*DEPTH)
//   dataDM      in   32      right-aligned store data
//   outDM       out  32      registered load data (held otherwise)
//   valid_DM    out  1       completion pulse, one per accepted request
//   err_DM      out  1       misaligned / illegal-size pulse with valid_DM
//   ready_DM    out  1       high once the clear sweep has finished
//
// DEPTH must be a power of two >= 4; ADDR_W must be >= log2(DEPTH)+2.
// ----------------------------------------------------------------------------
module datamem_byte #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_DM,
    input  logic              we_DM,
    input  logic [1:0]        size_DM,
    input  logic              unsigned_DM,
    input  logic [ADDR_W-1:0] addDM,
    input  logic [31:0]       dataDM,
    output logic [31:0]       outDM,
    output logic              valid_DM,
    output logic              err_DM,
    output logic              ready_DM
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic [31:0]        r_out;
    logic               r_valid;
    logic               r_err;
    logic               r_ready;
    logic [31:0]        r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_clr_cnt_nxt;
    logic [31:0]        w_out_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;
    logic               w_ready_nxt;

    logic [IDX_W-1:0]   w_idx;
    logic [1:0]         w_lane;
    logic               w_misaligned;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_shift;
    logic [31:0]        w_load_val;
    logic [31:0]        w_st_data;
    logic [3:0]         w_st_be;

    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_idx;
    logic [3:0]         w_mem_be;
    logic [31:0]        w_mem_wdata;

    logic               w_unused;

    // Upper address bits only wrap; they are deliberately not decoded.
    assign w_unused = &{1'b0, addDM};

    // Address decode: word index and byte lane.
    assign w_idx  = addDM[IDX_W+1:2];
    assign w_lane = addDM[1:0];

    // Alignment / legality check.
    always_comb begin
        w_misaligned = 1'b0;
        case (size_DM)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = addDM[0];
            SZ_WORD: w_misaligned = (addDM[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // Load path: read the addressed word, move the lane down, extend.
    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_load_val = w_rd_word;
        case (size_DM)
            SZ_BYTE: begin
                if (unsigned_DM) w_load_val = {24'h0, w_rd_shift[7:0]};
                else             w_load_val = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            end
            SZ_HALF: begin
                if (unsigned_DM) w_load_val = {16'h0, w_rd_shift[15:0]};
                else             w_load_val = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            end
            default: w_load_val = w_rd_word;
        endcase
    end

    // Store path: replicate data into every candidate lane, enable the target.
    always_comb begin
        w_st_data = dataDM;
        w_st_be   = 4'b1111;
        case (size_DM)
            SZ_BYTE: begin
                w_st_data = {4{dataDM[7:0]}};
                w_st_be   = 4'b0001 << w_lane;
            end
            SZ_HALF: begin
                w_st_data = {2{dataDM[15:0]}};
                w_st_be   = addDM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = dataDM;
                w_st_be   = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_out_nxt     = r_out;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_idx     = w_idx;
        w_mem_be      = 4'b0000;
        w_mem_wdata   = 32'h0;

        case (r_state)
            S_CLEAR: begin
                // Sweep one word per cycle; requests are ignored here.
                w_mem_we    = 1'b1;
                w_mem_idx   = r_clr_cnt;
                w_mem_be    = 4'b1111;
                w_mem_wdata = 32'h0;
                if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt   = S_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
                end
            end

            S_READY: begin
                if (req_DM) begin
                    w_valid_nxt = 1'b1;
                    if (w_misaligned) begin
                        w_err_nxt = 1'b1;
                    end else if (we_DM) begin
                        w_mem_we    = 1'b1;
                        w_mem_be    = w_st_be;
                        w_mem_wdata = w_st_data;
                    end else begin
                        w_out_nxt = w_load_val;
                    end
                end
            end

            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase

        w_ready_nxt = (w_state_nxt == S_READY);
    end

    // ------------------------------------------------------------------
    // State / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_out     <= 32'h0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Memory array: lane-enabled write; suppressed while reset is asserted
    // because the following clear sweep rewrites everything anyway.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign outDM    = r_out;
    assign valid_DM = r_valid;
    assign err_DM   = r_err;
    assign ready_DM = r_ready;

endmodule

// File: tb/tb_datamem_byte.sv
// ----------------------------------------------------------------------------
// tb_datamem_byte
//   Self-checking bench for datamem_byte. A byte-array model computes the
//   expected load data and error flags; directed scenarios cover the clear
//   sweep, extension, partial stores, misalignment, wrap, back-to-back and
//   reset during clear; a randomized back-to-back run follows.
// ----------------------------------------------------------------------------
module tb_datamem_byte;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NBYTES = 4 * DEPTH;

    logic              clk;
    logic              rst_n;
    logic              req_DM;
    logic              we_DM;
    logic [1:0]        size_DM;
    logic              unsigned_DM;
    logic [ADDR_W-1:0] addDM;
    logic [31:0]       dataDM;
    logic [31:0]       outDM;
    logic              valid_DM;
    logic              err_DM;
    logic              ready_DM;

    int n_vec;
    int n_err;

    // Byte-level reference memory and expected output register.
    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] ref_out;

    datamem_byte #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_DM      (req_DM),
        .we_DM       (we_DM),
        .size_DM     (size_DM),
        .unsigned_DM (unsigned_DM),
        .addDM       (addDM),
        .dataDM      (dataDM),
        .outDM       (outDM),
        .valid_DM    (valid_DM),
        .err_DM      (err_DM),
        .ready_DM    (ready_DM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void model_reset();
        for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;
        ref_out = 32'h0;
    endfunction

    function automatic void model_access(input bit we, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] addr,
                                         input logic [31:0] data, output bit exp_err);
        int unsigned a;
        int unsigned n;
        logic [31:0] v;
        a = addr % NBYTES;
        exp_err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
                  (sz == 2'd2 && (a % 4) != 0);
        if (exp_err) return;
        n = 1 << sz;
        if (we) begin
            for (int k = 0; k < int'(n); k++) ref_mem[a + k] = data[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < int'(n); k++) v = v | (32'(ref_mem[a + k]) << (8*k));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            ref_out = v;
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data);
        req_DM      = 1'b1;
        we_DM       = we;
        size_DM     = sz;
        unsigned_DM = uns;
        addDM       = addr;
        dataDM      = data;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_DM = 1'b0;
        repeat (3) step();
        n_vec++; if (outDM !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected %h", outDM, 32'h0); end
        n_vec++; if (valid_DM !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_DM); end
        n_vec++; if (err_DM !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_DM); end
        n_vec++; if (ready_DM !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready_DM); end
        model_reset();
    endtask

    // Release reset with a store held on req_DM; it must be ignored.
    task automatic test_clear();
        int cnt;
        int bad;
        bit e;
        cnt = 0;
        bad = 0;
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEAD_BEEF);
        while (ready_DM !== 1'b1 && cnt < 2000) begin
            if (valid_DM !== 1'b0 || err_DM !== 1'b0) bad++;
            cnt++;
            @(negedge clk);
        end
        req_DM = 1'b0;
        n_vec++; if (cnt != 256) begin n_err++; $display("FAIL clear_len: got %0d expected %0d", cnt, 256); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL clear_ignore_req: got %0d pulses expected 0", bad); end
        drive(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        step();
        req_DM = 1'b0;
        model_access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, e);
        n_vec++; if (valid_DM !== 1'b1 || err_DM !== 1'b0) begin n_err++; $display("FAIL clear_load_flags: got v=%b e=%b expected v=1 e=0", valid_DM, err_DM); end
        n_vec++; if (outDM !== 32'h0) begin n_err++; $display("FAIL clear_load_data: got %h expected %h", outDM, 32'h0); end
    endtask

    task automatic test_extend();
        logic [1:0]  sz  [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
        bit          uns [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'd8, 32'd8, 32'd8, 32'd10};
        logic [31:0] exv [4] = '{32'hABCD_EFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_ABCD};
        bit e;
        drive(1'b1, 2'd2, 1'b0, 32'd8, 32'hABCD_EFFF);
        step();
        model_access(1'b1, 2'd2, 1'b0, 32'd8, 32'hABCD_EFFF, e);
        n_vec++; if (valid_DM !== 1'b1 || err_DM !== 1'b0) begin n_err++; $display("FAIL ext_store_flags: got v=%b e=%b expected v=1 e=0", valid_DM, err_DM); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, sz[i], uns[i], ad[i], 32'h0);
            step();
            model_access(1'b0, sz[i], uns[i], ad[i], 32'h0, e);
            n_vec++; if (outDM !== exv[i] || valid_DM !== 1'b1) begin n_err++; $display("FAIL ext_load%0d: got %h v=%b expected %h v=1", i, outDM, valid_DM, exv[i]); end
        end
        req_DM = 1'b0;
    endtask

    task automatic test_partial_store();
        bit e;
        drive(1'b1, 2'd2, 1'b0, 32'd16, 32'h1234_5678); step(); model_access(1'b1, 2'd2, 1'b0, 32'd16, 32'h1234_5678, e);
        drive(1'b1, 2'd0, 1'b0, 32'd17, 32'hFFFF_FF5A); step(); model_access(1'b1, 2'd0, 1'b0, 32'd17, 32'hFFFF_FF5A, e);
        drive(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);         step(); model_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0, e);
        n_vec++; if (outDM !== 32'h1234_5A78) begin n_err++; $display("FAIL byte_store_merge: got %h expected %h", outDM, 32'h1234_5A78); end
        drive(1'b1, 2'd1, 1'b0, 32'd18, 32'h0000_BEEF); step(); model_access(1'b1, 2'd1, 1'b0, 32'd18, 32'h0000_BEEF, e);
        n_vec++; if (outDM !== 32'h1234_5A78) begin n_err++; $display("FAIL store_holds_out: got %h expected %h", outDM, 32'h1234_5A78); end
        drive(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);         step(); model_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0, e);
        n_vec++; if (outDM !== 32'hBEEF_5A78) begin n_err++; $display("FAIL half_store_merge: got %h expected %h", outDM, 32'hBEEF_5A78); end
        req_DM = 1'b0;
    endtask

    task automatic test_misalign();
        bit          we  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz  [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ad  [4] = '{32'd9, 32'h11, 32'd16, 32'd18};
        bit e;
        for (int i = 0; i < 4; i++) begin
            drive(we[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA);
            step();
            model_access(we[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, e);
            n_vec++; if (valid_DM !== 1'b1 || err_DM !== 1'b1) begin n_err++; $display("FAIL misalign%0d_flags: got v=%b e=%b expected v=1 e=1", i, valid_DM, err_DM); end
            n_vec++; if (outDM !== 32'hBEEF_5A78) begin n_err++; $display("FAIL misalign%0d_hold: got %h expected %h", i, outDM, 32'hBEEF_5A78); end
        end
        drive(1'b0, 2'd2, 1'b0, 32'd16, 32'h0); step(); model_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0, e);
        n_vec++; if (outDM !== 32'hBEEF_5A78 || err_DM !== 1'b0) begin n_err++; $display("FAIL misalign_mem_unchanged: got %h e=%b expected %h e=0", outDM, err_DM, 32'hBEEF_5A78); end
        req_DM = 1'b0;
    endtask

    task automatic test_wrap_back_to_back();
        bit e;
        drive(1'b1, 2'd2, 1'b0, 32'h408, 32'h0BAD_F00D); step(); model_access(1'b1, 2'd2, 1'b0, 32'h408, 32'h0BAD_F00D, e);
        drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);           step(); model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, e);
        n_vec++; if (outDM !== 32'h0BAD_F00D) begin n_err++; $display("FAIL wrap: got %h expected %h", outDM, 32'h0BAD_F00D); end
        drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hC0FF_EE11); step(); model_access(1'b1, 2'd2, 1'b0, 32'h40, 32'hC0FF_EE11, e);
        n_vec++; if (valid_DM !== 1'b1) begin n_err++; $display("FAIL b2b_store_valid: got %b expected 1", valid_DM); end
        drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);          step(); model_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, e);
        n_vec++; if (outDM !== 32'hC0FF_EE11 || valid_DM !== 1'b1) begin n_err++; $display("FAIL b2b_load: got %h v=%b expected %h v=1", outDM, valid_DM, 32'hC0FF_EE11); end
        req_DM = 1'b0;
        step();
        n_vec++; if (valid_DM !== 1'b0 || err_DM !== 1'b0 || outDM !== 32'hC0FF_EE11) begin n_err++; $display("FAIL idle: got v=%b e=%b out=%h expected v=0 e=0 out=%h", valid_DM, err_DM, outDM, 32'hC0FF_EE11); end
    endtask

    task automatic test_random();
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] ad;
        logic [31:0] dt;
        bit          e;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_DM = 1'b0;
                step();
                n_vec++; if (valid_DM !== 1'b0 || err_DM !== 1'b0 || outDM !== ref_out) begin n_err++; $display("FAIL rnd_idle%0d: got v=%b e=%b out=%h expected v=0 e=0 out=%h", i, valid_DM, err_DM, outDM, ref_out); end
            end else begin
                we  = 1'($urandom_range(0, 1));
                sz  = 2'($urandom_range(0, 3));
                uns = 1'($urandom_range(0, 1));
                ad  = ($urandom << 10) | 32'($urandom_range(0, 47));
                dt  = $urandom;
                drive(we, sz, uns, ad, dt);
                step();
                model_access(we, sz, uns, ad, dt, e);
                n_vec++; if (valid_DM !== 1'b1 || err_DM !== e || outDM !== ref_out) begin n_err++; $display("FAIL rnd%0d we=%b sz=%0d a=%h: got v=%b e=%b out=%h expected v=1 e=%b out=%h", i, we, sz, ad, valid_DM, err_DM, outDM, e, ref_out); end
            end
        end
        req_DM = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        int low100;
        bit e;
        drive(1'b1, 2'd2, 1'b0, 32'd8, 32'h7777_8888); step();
        // Load accepted on the same edge that samples reset: no completion.
        drive(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
        rst_n = 1'b0;
        step();
        n_vec++; if (valid_DM !== 1'b0 || outDM !== 32'h0) begin n_err++; $display("FAIL reset_discard: got v=%b out=%h expected v=0 out=0", valid_DM, outDM); end
        req_DM = 1'b0;
        rst_n  = 1'b1;
        low100 = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready_DM === 1'b0) low100++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        cnt = 0;
        while (ready_DM !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        n_vec++; if (low100 != 100) begin n_err++; $display("FAIL mid_clear_low: got %0d expected %0d", low100, 100); end
        n_vec++; if (cnt != 256) begin n_err++; $display("FAIL restart_clear_len: got %0d expected %0d", cnt, 256); end
        drive(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);  step(); model_access(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, e);
        n_vec++; if (outDM !== 32'h0 || valid_DM !== 1'b1) begin n_err++; $display("FAIL cleared_8: got %h v=%b expected 0 v=1", outDM, valid_DM); end
        drive(1'b0, 2'd2, 1'b0, 32'd16, 32'h0); step(); model_access(1'b0, 2'd2, 1'b0, 32'd16, 32'h0, e);
        n_vec++; if (outDM !== 32'h0) begin n_err++; $display("FAIL cleared_16: got %h expected 0", outDM); end
        drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0); step(); model_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, e);
        n_vec++; if (outDM !== 32'h0) begin n_err++; $display("FAIL cleared_40: got %h expected 0", outDM); end
        req_DM = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        req_DM      = 1'b0;
        we_DM       = 1'b0;
        size_DM     = 2'd0;
        unsigned_DM = 1'b0;
        addDM       = '0;
        dataDM      = 32'h0;
        @(negedge clk);
        test_reset();
        test_clear();
        test_extend();
        test_partial_store();
        test_misalign();
        test_wrap_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datamem_byte.md
DATAMEM_BYTE -- requirements
Module: datamem_byte

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of 2, >= 4).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req_DM  input  1  access request, one access per cycle.
REQ-006 The block SHALL have port we_DM  input  1  1 = store, 0 = load; sampled with req_DM.
REQ-007 The block SHALL have port size_DM  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port unsigned_DM  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-009 The block SHALL have port addDM  input  ADDR_W  byte address.
REQ-010 The block SHALL have port dataDM  input  32  store data, right-aligned.
REQ-011 The block SHALL have port outDM  output  32  registered load data.
REQ-012 The block SHALL have port valid_DM  output  1  one-cycle completion pulse for every accepted request.
REQ-013 The block SHALL have port err_DM  output  1  one-cycle misalign/illegal-size pulse, coincident with valid_DM.
REQ-014 The block SHALL have port ready_DM  output  1  1 = requests accepted; 0 during memory clear.

Function
REQ-015 The block SHALL implement a two-state FSM, CLEAR and READY; ready_DM = 1 only in READY.
REQ-016 In CLEAR, the block SHALL write zero to word index clr_cnt each cycle (clr_cnt 0..DEPTH-1), then enter READY the cycle after writing DEPTH-1; CLEAR lasts exactly DEPTH cycles.
REQ-017 In CLEAR, the block SHALL ignore req_DM: no write, no valid_DM, no err_DM.
REQ-018 The block SHALL compute word index = addDM[log2(DEPTH)+1:2] and lane = addDM[1:0]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-019 The block SHALL use little-endian lane order: lane 0 = bits 7:0, lane 3 = bits 31:24.
REQ-020 A request is misaligned when it is a half with addDM[0]=1, a word with addDM[1:0]!=0, or size_DM=11.
REQ-021 For an accepted aligned store in cycle N, the block SHALL update memory at the edge ending cycle N: byte writes dataDM[7:0] to the lane, half writes dataDM[15:0] to lanes {1,0} or {3,2} selected by addDM[1], and word writes all lanes; untouched lanes keep their value.
REQ-022 For an accepted aligned load in cycle N, the block SHALL present the extended data on outDM and pulse valid_DM in cycle N+1; byte/half are sign- or zero-extended per unsigned_DM; word ignores unsigned_DM.
REQ-023 For a store, the block SHALL pulse valid_DM in cycle N+1 and leave outDM unchanged.
REQ-024 For a misaligned request, the block SHALL not write memory, hold outDM, and pulse valid_DM=1 with err_DM=1 in cycle N+1.
REQ-025 A load in cycle N+1 to the address stored in cycle N SHALL return the new data (no stale read).
REQ-026 Back-to-back requests every cycle SHALL be supported at full throughput; valid_DM is high in every cycle following an accepted request.
REQ-027 With req_DM=0, the block SHALL keep valid_DM=0 and err_DM=0 next cycle and hold outDM.

Reset
REQ-028 When rst_n=0 is sampled at a rising edge, the block SHALL set the next state to outDM=0, valid_DM=0, err_DM=0, ready_DM=0, FSM=CLEAR, clr_cnt=0.
REQ-029 Reset during CLEAR SHALL restart the clear from index 0; reset in READY SHALL discard any in-flight completion (no valid_DM after reset).
REQ-030 Memory contents SHALL be all-zero on the first READY cycle after any reset.

Verification
REQ-031 The bench SHALL cover: release reset (DEPTH=256) -> ready_DM low exactly 256 cycles; a word load of 0x3FC then returns 0x00000000 with valid_DM.
REQ-032 The bench SHALL cover: word store 0xABCDEFFF at 8, word load 8 -> outDM=0xABCDEFFF; byte load 8 signed -> 0xFFFFFFFF; byte load 8 unsigned -> 0x000000FF; half load 10 signed -> 0xFFFFABCD.
REQ-033 The bench SHALL cover: word store 0x12345678 at 16, byte store 0x5A at 17, word load 16 -> 0x12345A78; half store 0xBEEF at 18, word load 16 -> 0xBEEF5A78.
REQ-034 The bench SHALL cover: word load at 9, half at 0x11, and size_DM=11 at 16 -> each gives valid_DM=1, err_DM=1, outDM held, memory unchanged (word load 16 still 0xBEEF5A78).
REQ-035 The bench SHALL cover: word store 0x0BADF00D at 0x408 -> word load 0x8 returns 0x0BADF00D (wrap); back-to-back store/load at the same address on consecutive cycles returns the new data.
REQ-036 The bench SHALL cover: assert rst_n=0 mid-CLEAR at count 100 -> ready_DM stays low 256 cycles after release; previously stored locations read 0.
